// File: rtl/mem_responder_pkg.sv
// Shared definitions for the memory responder: size encodings, FSM states
// and the transfer-length helper.
package mem_defs;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    XFER,
    DONE
  } state_t;

  // Number of byte transfers for a request size (reserved size maps to 1;
  // it is rejected before any transfer happens).
  function automatic logic [2:0] bytes_for_size(input logic [1:0] sz);
    case (sz)
      SZ_HALF: return 3'd2;
      SZ_WORD: return 3'd4;
      default: return 3'd1;
    endcase
  endfunction

endpackage

// File: rtl/mem_responder_byte_mem.sv
// Byte-wide single-port storage: synchronous write, combinational read.
// The array is named memory so benches can preload and dump it.
module byte_mem
  import mem_defs::*;
#(
  parameter int unsigned DEPTH  = 512,
  parameter int unsigned ADDR_W = 9
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [7:0]        wdata,
  output logic [7:0]        rdata
);

  logic [7:0] memory [0:DEPTH-1];

  // Write one byte at the addressed location.
  always_ff @(posedge clk) begin
    if (we) memory[addr] <= wdata;
  end

  assign rdata = memory[addr];

endmodule

// File: rtl/mem_responder.sv
// Memory-side responder for the MFA/MOC handshake. Serves byte, halfword and
// word accesses against a big-endian byte array, one byte per clock, after a
// configurable number of wait cycles.
module mem_responder
  import mem_defs::*;
#(
  parameter int unsigned DEPTH       = 512,
  parameter int unsigned ADDR_W      = 9,
  parameter int unsigned WAIT_CYCLES = 1
) (
  input  logic              main_clk,
  input  logic              reset,
  input  logic              mfa,
  input  logic              rw,
  input  logic [1:0]        size,
  input  logic [ADDR_W-1:0] address,
  input  logic [31:0]       data_in,
  output logic [31:0]       data_out,
  output logic              moc,
  output logic              err
);

  state_t            state, state_next;
  logic              rw_q, rw_next;
  logic [1:0]        size_q, size_next;
  logic [ADDR_W-1:0] addr_q, addr_next;
  logic [31:0]       din_q, din_next;
  logic [31:0]       hold_q, hold_next;
  logic [31:0]       dout_next;
  logic [1:0]        bcnt, bcnt_next;
  logic [3:0]        wcnt, wcnt_next;
  logic              moc_next, err_next;

  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [7:0]        mem_wdata, mem_rdata;
  logic [2:0]        nbytes;
  logic              last_byte;
  logic [1:0]        byte_sel;
  logic [31:0]       shifted;
  logic              req_err;

  assign nbytes    = bytes_for_size(size_q);
  assign last_byte = ({1'b0, bcnt} == (nbytes - 3'd1));
  // Big-endian: transfer k carries data_in byte (N-1-k), MSB first.
  assign byte_sel  = 2'(nbytes - 3'd1 - {1'b0, bcnt});
  assign mem_addr  = addr_q + ADDR_W'(bcnt);
  assign mem_wdata = din_q[{byte_sel, 3'b000} +: 8];
  assign shifted   = {hold_q[23:0], mem_rdata};
  assign req_err   = (size == 2'b11) ||
                     ((size == SZ_HALF) && address[0]) ||
                     ((size == SZ_WORD) && (address[1:0] != 2'b00));

  byte_mem #(
    .DEPTH (DEPTH),
    .ADDR_W(ADDR_W)
  ) byte_mem (
    .clk  (main_clk),
    .we   (mem_we),
    .addr (mem_addr),
    .wdata(mem_wdata),
    .rdata(mem_rdata)
  );

  // Register FSM state, handshake outputs, counters and the latched request.
  always_ff @(posedge main_clk) begin
    if (!reset) begin
      state    <= IDLE;
      moc      <= 1'b0;
      err      <= 1'b0;
      data_out <= '0;
      bcnt     <= '0;
      wcnt     <= '0;
      hold_q   <= '0;
      rw_q     <= 1'b0;
      size_q   <= '0;
      addr_q   <= '0;
      din_q    <= '0;
    end else begin
      state    <= state_next;
      moc      <= moc_next;
      err      <= err_next;
      data_out <= dout_next;
      bcnt     <= bcnt_next;
      wcnt     <= wcnt_next;
      hold_q   <= hold_next;
      rw_q     <= rw_next;
      size_q   <= size_next;
      addr_q   <= addr_next;
      din_q    <= din_next;
    end
  end

  // Next-state, byte transfer control and output updates.
  always_comb begin
    state_next = state;
    moc_next   = moc;
    err_next   = err;
    dout_next  = data_out;
    bcnt_next  = bcnt;
    wcnt_next  = wcnt;
    hold_next  = hold_q;
    rw_next    = rw_q;
    size_next  = size_q;
    addr_next  = addr_q;
    din_next   = din_q;
    mem_we     = 1'b0;

    case (state)
      IDLE: begin
        if (mfa) begin
          rw_next   = rw;
          size_next = size;
          addr_next = address;
          din_next  = data_in;
          bcnt_next = '0;
          wcnt_next = '0;
          hold_next = '0;
          if (req_err) begin
            moc_next   = 1'b1;
            err_next   = 1'b1;
            state_next = DONE;
          end else if (WAIT_CYCLES != 0) begin
            state_next = WAIT;
          end else begin
            state_next = XFER;
          end
        end
      end
      WAIT: begin
        if (!mfa) begin
          state_next = IDLE;
        end else if ((32'(wcnt) + 32'd1) >= WAIT_CYCLES) begin
          state_next = XFER;
        end else begin
          wcnt_next = wcnt + 4'd1;
        end
      end
      XFER: begin
        if (!mfa) begin
          state_next = IDLE;
        end else begin
          mem_we    = !rw_q && reset;
          hold_next = shifted;
          if (last_byte) begin
            if (rw_q) dout_next = shifted;
            moc_next   = 1'b1;
            state_next = DONE;
          end else begin
            bcnt_next = bcnt + 2'd1;
          end
        end
      end
      DONE: begin
        if (!mfa) begin
          moc_next   = 1'b0;
          err_next   = 1'b0;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

endmodule

// File: tb/tb_mem_responder.sv
// Self-checking bench for mem_responder (WAIT_CYCLES=1): table-driven
// transactions with a scoreboard queue, plus abort, reset and hold sequences.
module tb_mem_responder;
  import mem_defs::*;

  logic        main_clk;
  logic        reset;
  logic        mfa;
  logic        rw;
  logic [1:0]  size;
  logic [8:0]  address;
  logic [31:0] data_in;
  logic [31:0] data_out;
  logic        moc;
  logic        err;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic        rw;
    logic [1:0]  size;
    logic [8:0]  addr;
    logic [31:0] din;
    logic [31:0] dout;
    logic        err;
    int          lat;
  } vec_t;

  vec_t vecs[15];
  vec_t sb_q[$];

  mem_responder #(
    .DEPTH      (512),
    .ADDR_W     (9),
    .WAIT_CYCLES(1)
  ) dut (
    .main_clk(main_clk),
    .reset   (reset),
    .mfa     (mfa),
    .rw      (rw),
    .size    (size),
    .address (address),
    .data_in (data_in),
    .data_out(data_out),
    .moc     (moc),
    .err     (err)
  );

  initial main_clk = 1'b0;
  always #5 main_clk = ~main_clk;

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Issue one request, measure latency from the accept edge, compare against
  // the scoreboard, optionally hold mfa high, then release and check clear.
  task automatic run_vec(input vec_t v, input int hold, input string tag);
    int   e;
    bit   seen;
    vec_t exp;
    sb_q.push_back(v);
    @(negedge main_clk);
    rw      = v.rw;
    size    = v.size;
    address = v.addr;
    data_in = v.din;
    mfa     = 1'b1;
    e = 0;
    seen = 1'b0;
    while (!seen && e < 40) begin
      @(posedge main_clk);
      #1;
      if (e == 0) begin
        rw      = ~rw;
        size    = ~size;
        address = address ^ 9'h1ff;
        data_in = ~data_in;
      end
      if (moc) seen = 1'b1;
      else e++;
    end
    exp = sb_q.pop_front();
    check({tag, "_moc_seen"}, 32'(seen), 32'd1);
    check({tag, "_data_out"}, data_out, exp.dout);
    check({tag, "_err"}, 32'(err), 32'(exp.err));
    check({tag, "_latency"}, 32'(e), 32'(exp.lat));
    for (int h = 0; h < hold; h++) begin
      @(posedge main_clk);
      #1;
      check({tag, "_moc_hold"}, 32'(moc), 32'd1);
    end
    @(negedge main_clk);
    mfa = 1'b0;
    @(posedge main_clk);
    #1;
    check({tag, "_moc_clear"}, 32'(moc), 32'd0);
    check({tag, "_err_clear"}, 32'(err), 32'd0);
  endtask

  initial begin
    reset   = 1'b0;
    mfa     = 1'b0;
    rw      = 1'b0;
    size    = 2'b00;
    address = '0;
    data_in = '0;

    repeat (3) @(posedge main_clk);
    #1;
    check("reset_moc", 32'(moc), 32'd0);
    check("reset_err", 32'(err), 32'd0);
    check("reset_data_out", data_out, 32'd0);

    @(negedge main_clk);
    for (int i = 0; i < 512; i++) dut.byte_mem.memory[i] = 8'hC3;
    dut.byte_mem.memory[0]  = 8'h77;
    dut.byte_mem.memory[8]  = 8'hDE;
    dut.byte_mem.memory[9]  = 8'hAD;
    dut.byte_mem.memory[10] = 8'hBE;
    dut.byte_mem.memory[11] = 8'hEF;
    dut.byte_mem.memory[40] = 8'h11;
    dut.byte_mem.memory[41] = 8'h22;
    dut.byte_mem.memory[42] = 8'h33;
    dut.byte_mem.memory[43] = 8'h44;
    reset = 1'b1;

    //            rw    size     addr     din            dout           err   lat
    vecs[0]  = '{1'b1, SZ_WORD, 9'd8,   32'h0,         32'hDEADBEEF, 1'b0, 5};
    vecs[1]  = '{1'b0, SZ_HALF, 9'd20,  32'h0000_1234, 32'hDEADBEEF, 1'b0, 3};
    vecs[2]  = '{1'b1, SZ_BYTE, 9'd21,  32'h0,         32'h00000034, 1'b0, 2};
    vecs[3]  = '{1'b1, SZ_BYTE, 9'd20,  32'h0,         32'h00000012, 1'b0, 2};
    vecs[4]  = '{1'b1, SZ_HALF, 9'd20,  32'h0,         32'h00001234, 1'b0, 3};
    vecs[5]  = '{1'b1, SZ_WORD, 9'd6,   32'h0,         32'h00001234, 1'b1, 0};
    vecs[6]  = '{1'b1, SZ_HALF, 9'd3,   32'h0,         32'h00001234, 1'b1, 0};
    vecs[7]  = '{1'b1, 2'b11,   9'd0,   32'h0,         32'h00001234, 1'b1, 0};
    vecs[8]  = '{1'b0, SZ_WORD, 9'd100, 32'hCAFEF00D,  32'h00001234, 1'b0, 5};
    vecs[9]  = '{1'b1, SZ_WORD, 9'd100, 32'h0,         32'hCAFEF00D, 1'b0, 5};
    vecs[10] = '{1'b0, SZ_BYTE, 9'd511, 32'hFFFFFF99,  32'hCAFEF00D, 1'b0, 2};
    vecs[11] = '{1'b1, SZ_HALF, 9'd510, 32'h0,         32'h0000C399, 1'b0, 3};
    vecs[12] = '{1'b1, SZ_WORD, 9'd508, 32'h0,         32'hC3C3C399, 1'b0, 5};
    vecs[13] = '{1'b1, SZ_BYTE, 9'd0,   32'h0,         32'h00000077, 1'b0, 2};
    vecs[14] = '{1'b0, SZ_WORD, 9'd2,   32'h01020304,  32'h00000077, 1'b1, 0};

    for (int i = 0; i < 15; i++) begin
      run_vec(vecs[i], 0, $sformatf("vec%0d", i));
    end

    check("mem20", 32'(dut.byte_mem.memory[20]), 32'h12);
    check("mem21", 32'(dut.byte_mem.memory[21]), 32'h34);
    check("mem100", 32'(dut.byte_mem.memory[100]), 32'hCA);
    check("mem103", 32'(dut.byte_mem.memory[103]), 32'h0D);
    check("mem2_after_err", 32'(dut.byte_mem.memory[2]), 32'hC3);
    check("mem3_after_err", 32'(dut.byte_mem.memory[3]), 32'hC3);
    check("mem511", 32'(dut.byte_mem.memory[511]), 32'h99);

    // moc held for the extra mfa cycles, then back-to-back next request.
    run_vec('{1'b1, SZ_WORD, 9'd8, 32'h0, 32'hDEADBEEF, 1'b0, 5}, 3, "hold");
    run_vec('{1'b1, SZ_BYTE, 9'd21, 32'h0, 32'h00000034, 1'b0, 2}, 0, "after_hold");

    // Abort a word write after two bytes have been stored.
    @(negedge main_clk);
    rw      = 1'b0;
    size    = SZ_WORD;
    address = 9'd40;
    data_in = 32'hA1B2C3D4;
    mfa     = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(posedge main_clk);
      #1;
      check("abort_moc_busy", 32'(moc), 32'd0);
    end
    @(negedge main_clk);
    mfa = 1'b0;
    repeat (2) begin
      @(posedge main_clk);
      #1;
      check("abort_moc_after", 32'(moc), 32'd0);
    end
    check("abort_mem40", 32'(dut.byte_mem.memory[40]), 32'hA1);
    check("abort_mem41", 32'(dut.byte_mem.memory[41]), 32'hB2);
    check("abort_mem42", 32'(dut.byte_mem.memory[42]), 32'h33);
    check("abort_mem43", 32'(dut.byte_mem.memory[43]), 32'h44);
    check("abort_data_out", data_out, 32'h00000034);

    // Reset in the middle of a word read transfer.
    @(negedge main_clk);
    rw      = 1'b1;
    size    = SZ_WORD;
    address = 9'd8;
    mfa     = 1'b1;
    repeat (4) @(posedge main_clk);
    @(negedge main_clk);
    reset = 1'b0;
    @(posedge main_clk);
    #1;
    check("rst_moc", 32'(moc), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    check("rst_data_out", data_out, 32'd0);
    check("rst_state", 32'(dut.state), 32'(IDLE));
    @(negedge main_clk);
    reset = 1'b1;
    mfa   = 1'b0;
    @(posedge main_clk);
    run_vec('{1'b1, SZ_BYTE, 9'd0, 32'h0, 32'h00000077, 1'b0, 2}, 0, "post_rst");

    check("scoreboard_empty", 32'(sb_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
